// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter sharing one 8-bit address / 8-bit
// data slave bus among NUM_MASTERS requesters. The granted master's cycle is
// routed to the slave side, and a one-hot 16-block select is decoded from
// addr[7:4]. A watchdog ends any strobe that no slave acknowledges with a
// one-cycle err.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   m_cyc_i/m_stb_i/m_we_i    per-master cycle, strobe, write enable
//   m_addr_i/m_dat_i          packed per-master address / write data (8 bits each)
//   m_dat_o                   read data broadcast to all masters
//   m_ack_o/m_err_o           per-master ack / watchdog error
//   gnt_o                     registered one-hot grant
//   s_cyc_o/s_stb_o/s_we_o    slave cycle, strobe, write enable
//   s_addr_o/s_dat_o          slave address / write data
//   s_dat_i/s_ack_i           slave read data / ack
//   s_sel_o                   one-hot block select (bit = s_addr_o[7:4])
module wb_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned TO_W        = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_MASTERS-1:0]   m_cyc_i,
  input  logic [NUM_MASTERS-1:0]   m_stb_i,
  input  logic [NUM_MASTERS-1:0]   m_we_i,
  input  logic [8*NUM_MASTERS-1:0] m_addr_i,
  input  logic [8*NUM_MASTERS-1:0] m_dat_i,
  output logic [7:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]   m_ack_o,
  output logic [NUM_MASTERS-1:0]   m_err_o,
  output logic [NUM_MASTERS-1:0]   gnt_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [7:0]               s_addr_o,
  output logic [7:0]               s_dat_o,
  input  logic [7:0]               s_dat_i,
  input  logic                     s_ack_i,
  output logic [15:0]              s_sel_o
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [IW-1:0]        gnt_idx, gnt_idx_d;
  logic [IW-1:0]        rr_ptr, rr_ptr_d;
  logic [IW-1:0]        next_rr;
  logic [TO_W-1:0]      wd, wd_d;
  logic [NUM_MASTERS-1:0] gnt_d;

  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  int unsigned          cand;
  logic [IW-1:0]        cand_idx;

  logic                 sel_cyc, sel_stb, sel_we;
  logic [7:0]           sel_addr, sel_dat;

  // Signals of the currently granted master.
  always_comb begin
    sel_cyc  = m_cyc_i[gnt_idx];
    sel_stb  = m_stb_i[gnt_idx];
    sel_we   = m_we_i[gnt_idx];
    sel_addr = m_addr_i[32'(gnt_idx)*8 +: 8];
    sel_dat  = m_dat_i[32'(gnt_idx)*8 +: 8];
  end

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand     = (32'(rr_ptr) + i) % NUM_MASTERS;
      cand_idx = IW'(cand);
      if (!pick_valid && m_cyc_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign next_rr = (gnt_idx == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;

  // Next-state logic. A dropped cycle takes precedence over the watchdog,
  // and an ack in the limit cycle takes precedence over the error.
  always_comb begin
    state_d   = state;
    gnt_idx_d = gnt_idx;
    rr_ptr_d  = rr_ptr;
    wd_d      = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d   = BUSY;
          gnt_idx_d = pick_idx;
        end
      end
      BUSY: begin
        if (!sel_cyc) begin
          state_d  = IDLE;
          rr_ptr_d = next_rr;
        end else if (sel_stb && !s_ack_i) begin
          if (wd == TO_W'(TIMEOUT - 1)) begin
            state_d = ERR;
          end else begin
            wd_d = wd + 1'b1;
          end
        end
      end
      ERR: begin
        if (sel_cyc) begin
          state_d = BUSY;
        end else begin
          state_d  = IDLE;
          rr_ptr_d = next_rr;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = '0;
    if (state_d == BUSY || state_d == ERR) begin
      gnt_d[gnt_idx_d] = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      wd      <= '0;
      gnt_o   <= '0;
    end else begin
      state   <= state_d;
      gnt_idx <= gnt_idx_d;
      rr_ptr  <= rr_ptr_d;
      wd      <= wd_d;
      gnt_o   <= gnt_d;
    end
  end

  // Bus routing. Strobe is qualified by cycle so a stray strobe never
  // reaches the slaves.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    case (state)
      BUSY: begin
        s_cyc_o           = sel_cyc;
        s_stb_o           = sel_cyc & sel_stb;
        s_we_o            = sel_we;
        s_addr_o          = sel_addr;
        s_dat_o           = sel_dat;
        m_ack_o[gnt_idx]  = s_ack_i;
      end
      ERR: begin
        m_err_o[gnt_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_sel_o = '0;
    if (s_cyc_o && s_stb_o) begin
      s_sel_o[s_addr_o[7:4]] = 1'b1;
    end
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone arbiter sharing the single 8-bit-address / 8-bit-data slave bus among NUM_MASTERS requesters (host interface, MIDI port engines).
- Routes the granted master's cycle to the coarse-address slave space (16 blocks of 16 addresses, block = addr[7:4]) and drives a one-hot block select.
- Returns ack/read data to the granted master.
- A watchdog terminates with err any strobe that no slave acknowledges.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT, 16, cycles of unacknowledged s_stb_o before err (2..255).
- TO_W, 8, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- wb_clk_i  input  1  bus clock; all state on rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- m_cyc_i  input  NUM_MASTERS  per-master cycle request.
- m_stb_i  input  NUM_MASTERS  per-master strobe.
- m_we_i  input  NUM_MASTERS  per-master write enable.
- m_addr_i  input  8*NUM_MASTERS  packed addresses; master k at [8k+7:8k].
- m_dat_i  input  8*NUM_MASTERS  packed write data; same packing.
- m_dat_o  output  8  read data broadcast to all masters (= s_dat_i).
- m_ack_o  output  NUM_MASTERS  per-master ack.
- m_err_o  output  NUM_MASTERS  per-master error (watchdog).
- gnt_o  output  NUM_MASTERS  one-hot registered grant.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_we_o  output  1  slave write enable.
- s_addr_o  output  8  slave address.
- s_dat_o  output  8  slave write data.
- s_dat_i  input  8  read data from slave read mux.
- s_ack_i  input  1  slave ack.
- s_sel_o  output  16  one-hot block select, bit = s_addr_o[7:4].

Behaviour:
- Reset (async, wb_rst_i=1):
  - gnt_o=0, state=IDLE, watchdog=0, rr pointer so master 0 has highest priority.
  - All s_* outputs 0, m_ack_o=0, m_err_o=0.
- States:
  - IDLE: no grant.
  - BUSY: one master granted.
  - ERR: one-cycle error termination.
- IDLE:
  - If any m_cyc_i is set, grant the first requester at or after the rr pointer (wrapping) on the next edge. Latency: m_cyc_i rise to gnt_o = 1 cycle. Go to BUSY.
  - No requester: stay IDLE.
- BUSY, granted master g:
  - s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g]; s_we_o/s_addr_o/s_dat_o taken from g. These are combinational from the grant.
  - m_ack_o[g]=s_ack_i. All other acks/errs are 0.
  - Grant is held while m_cyc_i[g]=1; back-to-back strobes are allowed.
  - When m_cyc_i[g]=0 at an edge: gnt_o clears, rr pointer = g+1 mod NUM_MASTERS, go to IDLE. Re-arbitration happens the following cycle, so there is one dead cycle between owners.
- Slave outputs when no grant: s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o = 0 and s_sel_o=0.
- s_sel_o = one-hot of s_addr_o[7:4] when s_cyc_o & s_stb_o, else 0.
- Watchdog (BUSY only):
  - Increments each cycle with s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i, on s_stb_o=0, or on leaving BUSY.
  - Reaching TIMEOUT-1 with no ack in that cycle: next state ERR.
- ERR:
  - m_err_o[g]=1 for exactly one cycle; s_stb_o and s_cyc_o forced 0; watchdog cleared.
  - Then BUSY if m_cyc_i[g] is still 1, else IDLE with rr pointer advanced.
- Boundary conditions:
  - Ack in the same cycle the watchdog hits its limit: ack wins, no err.
  - m_cyc_i[g] drops mid-strobe: release, no err, watchdog cleared; a late s_ack_i is ignored because no master is granted.
  - m_stb_i without m_cyc_i is ignored.
  - rr pointer wraps NUM_MASTERS-1 to 0.
  - Reset asserted mid-transfer: everything clears immediately, without waiting for a clock edge.
- Width rules:
  - Grant index is clog2(NUM_MASTERS) bits.
  - Unused upper grant codes are unreachable; the default branch returns to IDLE.

Test Plan:
1. Reset mid-BUSY with master 2 granted -> gnt_o, s_cyc_o and s_sel_o are 0 in the same cycle; after release, a lone request from master 0 gets gnt_o=4'b0001 one cycle later.
2. Masters 0 and 1 both holding cyc continuously, each releasing after one ack -> grants alternate 0001, 0010, 0001, with one idle cycle between each.
3. Master 3 single read, addr=8'h5A, slave acks with s_dat_i=8'hC3 two cycles after stb -> s_sel_o=16'h0020, m_ack_o=4'b1000 for one cycle, m_dat_o=8'hC3.
4. Master 1 strobes addr 8'hF0, no ack, TIMEOUT=16 -> m_err_o[1] pulses exactly once, 16 cycles after stb rise; s_stb_o=0 in that cycle; no ack seen.
5. s_ack_i arrives in the cycle the watchdog count reaches 15 -> m_ack_o asserted, m_err_o stays 0.
6. Master 2 drops cyc while strobing, then a late s_ack_i arrives -> gnt_o=0, m_ack_o=0, and the next arbitration favours master 3 over master 0.
